// File: rtl/seg7_pkg.sv
// Shared types and constants for the GPIO seven-segment display: FSM states,
// the active-low DE2 segment table and the binary-to-BCD conversion helpers.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam int BIN_W       = 32;
  localparam int BCD_DIGITS  = 10;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int DISP_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) r[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digits above the most-significant nonzero digit; digit 0 is never blanked.
  function automatic logic [DISP_DIGITS-1:0] lead_zero_mask(input logic [4*DISP_DIGITS-1:0] nibs);
    logic [DISP_DIGITS-1:0] m;
    logic                   zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = DISP_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (nibs[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/gpio_seg_display.sv
// CPU GPIO word to eight seven-segment digits, hex or decimal (serial double dabble).
// Optional macro GPIO_SEG_BLANK_EN blanks leading zero digits in both modes.
module gpio_seg_display
  import seg7_pkg::*;
#(
  parameter int   DIGITS       = 8,
  parameter logic HEX_MODE_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gpio_we,
  input  logic [31:0] gpio_wdata,
  input  logic        mode_hex,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic        busy,
  output logic        overflow
);

  state_e                     state_q, state_d;
  logic [BIN_W-1:0]           bin_q, bin_d;
  logic [BCD_W-1:0]           bcd_q, bcd_d;
  logic [BCD_W-1:0]           bcd_adj;
  logic [4:0]                 cnt_q, cnt_d;
  logic                       pend_valid_q, pend_valid_d;
  logic [31:0]                pend_data_q, pend_data_d;
  logic                       pend_mode_q, pend_mode_d;
  logic                       ovf_q, ovf_d;
  logic [DIGITS-1:0][6:0]     hex_q, hex_d;
  logic [DIGITS-1:0][6:0]     enc_seg;
  logic [DIGITS-1:0]          blank_mask;
  logic                       load_en;
  logic [4*DIGITS-1:0]        load_nib;
  logic [31:0]                req_data;
  logic                       req_mode;

  assign bcd_adj = bcd_adjust(bcd_q);

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_mode_d  = pend_mode_q;
    ovf_d        = ovf_q;
    load_en      = 1'b0;
    load_nib     = '0;
    // A live strobe in IDLE is newer than anything pending, so it takes priority.
    req_data     = gpio_we ? gpio_wdata : pend_data_q;
    req_mode     = gpio_we ? mode_hex : pend_mode_q;

    case (state_q)
      ST_IDLE: begin
        if (gpio_we || pend_valid_q) begin
          pend_valid_d = 1'b0;
          if (req_mode) begin
            load_en  = 1'b1;
            load_nib = req_data;
            ovf_d    = 1'b0;
          end else begin
            bin_d   = req_data;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_en  = 1'b1;
        load_nib = bcd_q[4*DIGITS-1:0];
        ovf_d    = |bcd_q[BCD_W-1:4*DIGITS];
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && gpio_we) begin
      pend_valid_d = 1'b1;
      pend_data_d  = gpio_wdata;
      pend_mode_d  = mode_hex;
    end
  end

`ifdef GPIO_SEG_BLANK_EN
  assign blank_mask = lead_zero_mask(load_nib);
`else
  assign blank_mask = '0;
`endif

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      seg7_encode u_enc (
        .nib (load_nib[4*gi +: 4]),
        .seg (enc_seg[gi])
      );
      assign hex_d[gi] = load_en ? (blank_mask[gi] ? SEG_BLANK : enc_seg[gi]) : hex_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_mode_q  <= HEX_MODE_RST;
      ovf_q        <= 1'b0;
      hex_q        <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_mode_q  <= pend_mode_d;
      ovf_q        <= ovf_d;
      hex_q        <= hex_d;
    end
  end

  assign HEX0     = hex_q[0];
  assign HEX1     = hex_q[1];
  assign HEX2     = hex_q[2];
  assign HEX3     = hex_q[3];
  assign HEX4     = hex_q[4];
  assign HEX5     = hex_q[5];
  assign HEX6     = hex_q[6];
  assign HEX7     = hex_q[7];
  assign busy     = (state_q != ST_IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_gpio_seg_display.sv
// Directed self-checking bench for gpio_seg_display (hex/decimal paths, pending write, reset).
module tb_gpio_seg_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        gpio_we;
  logic [31:0] gpio_wdata;
  logic        mode_hex;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic        busy;
  logic        overflow;
  logic [55:0] hex_all;

  int checks = 0;
  int errors = 0;

  gpio_seg_display dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_we    (gpio_we),
    .gpio_wdata (gpio_wdata),
    .mode_hex   (mode_hex),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5),
    .HEX6       (HEX6),
    .HEX7       (HEX7),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  // Expected display for 8 nibbles (BCD digits in decimal mode).
  function automatic logic [55:0] disp(input logic [31:0] v);
    logic [6:0]  t [16];
    logic [55:0] r;
    logic [3:0]  nib;
    logic [6:0]  s;
    logic        z;
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    r = '0;
    z = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      nib = v[4*i +: 4];
      s   = t[nib];
`ifdef GPIO_SEG_BLANK_EN
      if (i != 0) begin
        z = z && (nib == 4'd0);
        if (z) s = 7'h7F;
      end
`endif
      r[7*i +: 7] = s;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] data, input logic mode);
    gpio_we    = 1'b1;
    gpio_wdata = data;
    mode_hex   = mode;
    tick();
    gpio_we    = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    chk("idle_within_budget", 64'(busy), 64'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int busy_cnt;

    rst        = 1'b1;
    gpio_we    = 1'b1;
    gpio_wdata = 32'h1234_5678;
    mode_hex   = 1'b1;
    ticks(2);
    rst     = 1'b0;
    gpio_we = 1'b0;
    chk("reset_hex_blank", {8'h0, hex_all}, {8'h0, {8{7'h7F}}});
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    tick();
    chk("we_during_rst_ignored", {8'h0, hex_all}, {8'h0, {8{7'h7F}}});
    $display("reset with concurrent write: hex=%h busy=%0d", hex_all, busy);

    do_write(32'h1234_5678, 1'b1);
    chk("hex_12345678", {8'h0, hex_all}, {8'h0, disp(32'h1234_5678)});
    chk("hex_busy_low", 64'(busy), 64'd0);
    $display("hex write 12345678: hex=%h", hex_all);

    do_write(32'd2, 1'b0);
    busy_cnt = 0;
    for (int i = 1; i <= 33; i++) begin
      if (busy) busy_cnt++;
      if (i < 33) tick();
    end
    chk("dec2_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("dec2_hold_during_conv", {8'h0, hex_all}, {8'h0, disp(32'h1234_5678)});
    tick();
    chk("dec2_hex", {8'h0, hex_all}, {8'h0, disp(32'h0000_0002)});
    chk("dec2_hex0", 64'(HEX0), 64'(7'b0100100));
    chk("dec2_busy_done", 64'(busy), 64'd0);
    chk("dec2_overflow", 64'(overflow), 64'd0);
    $display("decimal write 2: hex=%h overflow=%0d", hex_all, overflow);

    do_write(32'd100000000, 1'b0);
    wait_idle(60);
    chk("dec1e8_hex", {8'h0, hex_all}, {8'h0, disp(32'h0000_0000)});
    chk("dec1e8_overflow", 64'(overflow), 64'd1);
    $display("decimal write 100000000: hex=%h overflow=%0d", hex_all, overflow);

    do_write(32'd99999999, 1'b0);
    wait_idle(60);
    chk("dec99999999_hex", {8'h0, hex_all}, {8'h0, disp(32'h9999_9999)});
    chk("dec99999999_overflow", 64'(overflow), 64'd0);
    $display("decimal write 99999999: hex=%h overflow=%0d", hex_all, overflow);

    do_write(32'hFFFF_FFFF, 1'b0);
    wait_idle(60);
    chk("decmax_hex", {8'h0, hex_all}, {8'h0, disp(32'h9496_7295)});
    chk("decmax_overflow", 64'(overflow), 64'd1);
    $display("decimal write 4294967295: hex=%h overflow=%0d", hex_all, overflow);

    do_write(32'hFEDC_BA98, 1'b1);
    chk("hex_fedcba98", {8'h0, hex_all}, {8'h0, disp(32'hFEDC_BA98)});
    chk("hex_clears_overflow", 64'(overflow), 64'd0);
    $display("hex write FEDCBA98: hex=%h overflow=%0d", hex_all, overflow);

    do_write(32'd5, 1'b0);
    ticks(2);
    do_write(32'd7, 1'b0);
    ticks(6);
    do_write(32'h0000_000A, 1'b1);
    ticks(22);
    chk("pend_still_busy_t33", 64'(busy), 64'd1);
    tick();
    chk("pend_dec5_hex", {8'h0, hex_all}, {8'h0, disp(32'h0000_0005)});
    tick();
    chk("pend_hexA_hex", {8'h0, hex_all}, {8'h0, disp(32'h0000_000A)});
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy) busy_cnt++;
      tick();
    end
    chk("pend_no_extra_conv", 64'(busy_cnt), 64'd0);
    chk("pend_hexA_hold", {8'h0, hex_all}, {8'h0, disp(32'h0000_000A)});
    $display("5 then 7 then hex A: hex=%h", hex_all);

    do_write(32'd12, 1'b0);
    ticks(32);
    do_write(32'h0000_0077, 1'b1);
    chk("load_write_dec12", {8'h0, hex_all}, {8'h0, disp(32'h0000_0012)});
    tick();
    chk("load_write_hex77", {8'h0, hex_all}, {8'h0, disp(32'h0000_0077)});
    chk("load_write_busy", 64'(busy), 64'd0);
    $display("write during LOAD: hex=%h", hex_all);

    do_write(32'd1000000000, 1'b0);
    wait_idle(60);
    chk("dec1e9_overflow", 64'(overflow), 64'd1);
    do_write(32'd123, 1'b0);
    ticks(19);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midconv_rst_hex", {8'h0, hex_all}, {8'h0, {8{7'h7F}}});
    chk("midconv_rst_busy", 64'(busy), 64'd0);
    chk("midconv_rst_overflow", 64'(overflow), 64'd0);
    ticks(3);
    chk("midconv_rst_stays_blank", {8'h0, hex_all}, {8'h0, {8{7'h7F}}});
    $display("reset at conversion cycle 20: hex=%h busy=%0d", hex_all, busy);

    do_write(32'd456, 1'b0);
    wait_idle(60);
    chk("after_rst_dec456", {8'h0, hex_all}, {8'h0, disp(32'h0000_0456)});
    $display("decimal write 456 after reset: hex=%h", hex_all);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_seg_display.md
GPIO_SEG_DISPLAY -- requirements
Module: gpio_seg_display

Interface
- REQ-001: Parameter DIGITS, default 8: number of seven-segment digits driven; fixed at 8 in this revision.
- REQ-002: Parameter HEX_MODE_RST, default 1'b1: display mode after reset (1 = hex, 0 = decimal).
- REQ-003: One clock; reset is synchronous and active-high.
- REQ-004: clk  input  1  system clock; all state changes on its rising edge.
- REQ-005: rst  input  1  synchronous active-high reset.
- REQ-006: gpio_we  input  1  CPU GPIO write strobe, one-cycle pulse per write.
- REQ-007: gpio_wdata  input  32  CPU GPIO write data, unsigned.
- REQ-008: mode_hex  input  1  display mode; sampled together with gpio_wdata when gpio_we=1.
- REQ-009: HEX0..HEX7  output  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 is the least-significant digit.
- REQ-010: busy  output  1  decimal conversion in progress.
- REQ-011: overflow  output  1  last displayed decimal value was >= 100000000.

Function
- REQ-012: The FSM SHALL have states IDLE, CONV and LOAD.
- REQ-013: In IDLE with gpio_we=1 and mode_hex=1, the SHALL requirement is: HEX outputs show the 8 nibbles of gpio_wdata on the next edge (1-cycle latency), overflow is cleared, and the FSM stays in IDLE.
- REQ-014: In IDLE with gpio_we=1 and mode_hex=0, the block SHALL latch gpio_wdata and enter CONV.
- REQ-015: CONV SHALL run a double-dabble conversion for exactly 32 cycles (one shift per cycle) into 10 BCD digits, then enter LOAD.
- REQ-016: LOAD SHALL register the low 8 BCD digits to HEX7..HEX0, set overflow = (either upper BCD digit nonzero), and return to IDLE; total latency from the write edge to updated HEX outputs is 34 cycles.
- REQ-017: busy SHALL be 1 in CONV and LOAD and 0 otherwise.
- REQ-018: A write accepted while busy=1 SHALL be stored in a one-deep pending register (data and mode); a later write while busy overwrites the pending entry (last write wins).
- REQ-019: On the LOAD→IDLE transition with a pending entry, the FSM SHALL process the pending entry on the next cycle as if it were a fresh write, then clear pending.
- REQ-020: A write arriving in the same cycle as LOAD SHALL become the pending entry, so it is not lost.
- REQ-021: HEX outputs SHALL hold their value between updates; no intermediate conversion state is ever visible.
- REQ-022: Segment encoding for 0-F SHALL be the standard DE2 active-low table (0 = 7'b1000000, 2 = 7'b0100100, 8 = 7'b0000000, F = 7'b0001110).

Reset
- REQ-023: rst SHALL force IDLE, all HEX outputs to 7'h7F (blank), busy=0, overflow=0, pending cleared, and mode to HEX_MODE_RST, including when asserted during CONV or LOAD.
- REQ-024: A gpio_we asserted in the same cycle as rst SHALL be ignored.

Configuration
- REQ-025: Macro GPIO_SEG_BLANK_EN: when defined, leading zero digits above the most-significant nonzero digit SHALL display 7'h7F, and a value of 0 SHALL show only HEX0 = "0"; blanking applies in both modes.
- REQ-026: When GPIO_SEG_BLANK_EN is not defined, all 8 digits SHALL always be displayed, including leading zeros.

Structure
- REQ-027: Package seg7_pkg SHALL hold the FSM state enum, the 16-entry segment constant table, the SEG_BLANK constant (7'h7F) and the BCD width constants.
- REQ-028: Sub-module seg7_encode (4-bit nibble in, 7-bit segments out, combinational) SHALL be instantiated once per digit.

Verification
- REQ-029: Hex write of 0x12345678 -> one cycle later HEX7..HEX0 = "1".."8", busy never asserted.
- REQ-030: Decimal write of 2 -> busy for 33 cycles; at the write edge +34, HEX0 = 7'b0100100 and HEX7..HEX1 = "0" (blank with GPIO_SEG_BLANK_EN), overflow=0.
- REQ-031: Decimal write of 100000000 -> HEX all "0", overflow=1; then decimal write of 99999999 -> all "9", overflow=0.
- REQ-032: Decimal 5 followed at +3 by decimal 7 and at +10 by hex 0xA -> display 5, then HEX0 = "A" (7 dropped), with no extra conversion.
- REQ-033: rst asserted at cycle 20 of a conversion -> next cycle HEX all 7'h7F, busy=0, and a subsequent write converts normally.
